// File: rtl/j_count_ctrl.sv
// j_count_ctrl
// Sequencing controller for a W-bit Johnson shift counter (j_count). The
// counter shifts Q <= {Q[W-2:0], din} on every rising clk; this block
// drives din and observes Q through q_in.
//
// Ports:
//   clk        system clock, rising edge
//   reset      asynchronous active-low reset
//   cmd_run    start stepping (accepted in IDLE)
//   cmd_load   start serial load of load_pat (accepted in IDLE)
//   cmd_stop   abort any operation, return to IDLE
//   load_pat   pattern captured when cmd_load is accepted
//   run_len    step count captured on cmd_run, 0 = free-run
//   q_in       parallel Q from j_count
//   din        serial input to j_count (combinational)
//   busy       high in any state other than IDLE
//   load_done  one-cycle pulse when a load completes
//   run_done   one-cycle pulse when a bounded run completes
//   phase      Johnson index of q_in, 0 when illegal
//   illegal    q_in is not one of the 2W Johnson codes
//   err_flag   sticky, set when RUN sees an illegal code
//
// state | meaning
// IDLE  | waiting for a command, din=0
// LOAD  | shifting pat_sr out MSB first for W cycles
// RUN   | Johnson stepping, din=~q_in[W-1]
// FLUSH | W cycles of din=0 to clear an illegal code, then back to RUN

module j_count_ctrl #(
   parameter int W     = 4,
   parameter int LEN_W = 8
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     cmd_run,
   input  logic                     cmd_load,
   input  logic                     cmd_stop,
   input  logic [W-1:0]             load_pat,
   input  logic [LEN_W-1:0]         run_len,
   input  logic [W-1:0]             q_in,
   output logic                     din,
   output logic                     busy,
   output logic                     load_done,
   output logic                     run_done,
   output logic [$clog2(2*W)-1:0]   phase,
   output logic                     illegal,
   output logic                     err_flag
);

   localparam int PW = $clog2(2*W);
   localparam int CW = (W > 2) ? $clog2(W) : 1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOAD  = 2'd1,
      RUN   = 2'd2,
      FLUSH = 2'd3
   } state_t;

   state_t            state;
   logic [W-1:0]      pat_sr;
   logic [CW-1:0]     bit_cnt;
   logic [LEN_W-1:0]  step_cnt;

   logic [PW:0]       ones;
   logic [PW:0]       trans;

   // A Johnson code has at most one transition between adjacent bits.
   // Codes with bit 0 set are on the rising half of the ring (index = ones),
   // the rest are on the falling half (index = 2W - ones, or 0 for all-zero).
   always_comb begin
      ones  = '0;
      trans = '0;
      for (int i = 0; i < W; i++) begin
         ones = ones + {{PW{1'b0}}, q_in[i]};
      end
      for (int i = 0; i < W-1; i++) begin
         trans = trans + {{PW{1'b0}}, q_in[i] ^ q_in[i+1]};
      end
      illegal = (trans > {{PW{1'b0}}, 1'b1});
      phase   = '0;
      if (!illegal) begin
         if (q_in[0]) begin
            phase = ones[PW-1:0];
         end else if (ones != '0) begin
            // PW'(2*W) wraps to 0 when 2W is a power of two; modulo math still holds
            phase = PW'(2*W) - ones[PW-1:0];
         end
      end
   end

   always_comb begin
      din = 1'b0;
      case (state)
         LOAD:    din = pat_sr[W-1];
         RUN:     din = ~q_in[W-1];
         default: din = 1'b0;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= IDLE;
         busy      <= 1'b0;
         load_done <= 1'b0;
         run_done  <= 1'b0;
         err_flag  <= 1'b0;
         pat_sr    <= '0;
         bit_cnt   <= '0;
         step_cnt  <= '0;
      end else begin
         load_done <= 1'b0;
         run_done  <= 1'b0;
         if (cmd_stop) begin
            state <= IDLE;
            busy  <= 1'b0;
         end else begin
            case (state)
               IDLE: begin
                  if (cmd_load) begin
                     state    <= LOAD;
                     busy     <= 1'b1;
                     pat_sr   <= load_pat;
                     bit_cnt  <= '0;
                     err_flag <= 1'b0;
                  end else if (cmd_run) begin
                     state    <= RUN;
                     busy     <= 1'b1;
                     step_cnt <= run_len;
                     err_flag <= 1'b0;
                  end
               end
               LOAD: begin
                  pat_sr <= {pat_sr[W-2:0], 1'b0};
                  if (bit_cnt == CW'(W-1)) begin
                     state     <= IDLE;
                     busy      <= 1'b0;
                     load_done <= 1'b1;
                  end else begin
                     bit_cnt <= bit_cnt + 1'b1;
                  end
               end
               RUN: begin
                  if (illegal) begin
                     state    <= FLUSH;
                     err_flag <= 1'b1;
                     bit_cnt  <= '0;
                  end else if (step_cnt != '0) begin
                     // step_cnt of 0 means free-run: no countdown, no done
                     step_cnt <= step_cnt - 1'b1;
                     if (step_cnt == LEN_W'(1)) begin
                        state    <= IDLE;
                        busy     <= 1'b0;
                        run_done <= 1'b1;
                     end
                  end
               end
               FLUSH: begin
                  if (bit_cnt == CW'(W-1)) begin
                     state <= RUN;
                  end else begin
                     bit_cnt <= bit_cnt + 1'b1;
                  end
               end
               default: begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_j_count_ctrl.sv
// Testbench for j_count_ctrl. Includes a behavioural j_count shift register
// as the environment and a ring-index reference model of the controller.
module tb_j_count_ctrl;

   localparam int W     = 4;
   localparam int LEN_W = 8;
   localparam int PW    = $clog2(2*W);

   logic              clk = 1'b0;
   logic              reset;
   logic              cmd_run, cmd_load, cmd_stop;
   logic [W-1:0]      load_pat;
   logic [LEN_W-1:0]  run_len;
   logic [W-1:0]      jq = 4'b1011;
   logic              din, busy, load_done, run_done, illegal, err_flag;
   logic [PW-1:0]     phase;

   int errors = 0;
   int checks = 0;

   logic [W-1:0] mq;     // expected counter contents
   logic         merr;   // expected err_flag

   always #5 clk = ~clk;

   // j_count datapath
   always @(posedge clk) jq <= {jq[W-2:0], din};

   j_count_ctrl #(.W(W), .LEN_W(LEN_W)) dut (
      .clk(clk), .reset(reset), .cmd_run(cmd_run), .cmd_load(cmd_load),
      .cmd_stop(cmd_stop), .load_pat(load_pat), .run_len(run_len),
      .q_in(jq), .din(din), .busy(busy), .load_done(load_done),
      .run_done(run_done), .phase(phase), .illegal(illegal), .err_flag(err_flag)
   );

   // k-th Johnson code: k ones filling from the bottom, then zeros filling from the bottom
   function automatic logic [W-1:0] jcode(input int k);
      if (k <= W) return W'((1 << k) - 1);
      return ~W'((1 << (k - W)) - 1);
   endfunction

   function automatic int jindex(input logic [W-1:0] v);
      for (int k = 0; k < 2*W; k++) if (jcode(k) == v) return k;
      return -1;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic step(input logic b);
      tick();
      mq = {mq[W-2:0], b};
      chk("q", 32'(jq), 32'(mq));
   endtask

   task automatic idle_cycles(input int n);
      for (int i = 0; i < n; i++) begin
         chk("idle_busy", 32'(busy), 32'(0));
         chk("idle_din", 32'(din), 32'(0));
         step(1'b0);
      end
   endtask

   task automatic do_load(input logic [W-1:0] pat);
      int idx;
      load_pat = pat;
      cmd_load = 1'b1;
      chk("ld_acc_busy", 32'(busy), 32'(0));
      step(1'b0);
      cmd_load = 1'b0;
      merr = 1'b0;
      for (int k = 0; k < W; k++) begin
         chk("ld_busy", 32'(busy), 32'(1));
         chk("ld_done_early", 32'(load_done), 32'(0));
         chk("ld_din", 32'(din), 32'(pat[W-1-k]));
         step(pat[W-1-k]);
      end
      idx = jindex(pat);
      chk("ld_done", 32'(load_done), 32'(1));
      chk("ld_busy_end", 32'(busy), 32'(0));
      chk("ld_q", 32'(jq), 32'(pat));
      chk("ld_illegal", 32'(illegal), 32'(idx < 0));
      chk("ld_phase", 32'(phase), 32'((idx < 0) ? 0 : idx));
      chk("ld_err", 32'(err_flag), 32'(merr));
      step(1'b0);
      chk("ld_done_pulse", 32'(load_done), 32'(0));
   endtask

   // Accept a run and handle an illegal start; returns the ring index reached.
   task automatic run_start(input int n, output int idx);
      logic b;
      run_len = LEN_W'(n);
      cmd_run = 1'b1;
      chk("rn_acc_busy", 32'(busy), 32'(0));
      step(1'b0);
      cmd_run = 1'b0;
      merr = 1'b0;
      if (jindex(mq) < 0) begin
         chk("rn_ill", 32'(illegal), 32'(1));
         chk("rn_ill_phase", 32'(phase), 32'(0));
         chk("rn_ill_err", 32'(err_flag), 32'(0));
         b = ~mq[W-1];
         step(b);
         merr = 1'b1;
         for (int k = 0; k < W; k++) begin
            chk("fl_busy", 32'(busy), 32'(1));
            chk("fl_err", 32'(err_flag), 32'(1));
            chk("fl_din", 32'(din), 32'(0));
            step(1'b0);
         end
         chk("fl_q0", 32'(jq), 32'(0));
      end
      idx = jindex(mq);
   endtask

   task automatic run_step(inout int idx);
      logic [W-1:0] nxt;
      nxt = jcode((idx + 1) % (2*W));
      chk("rn_busy", 32'(busy), 32'(1));
      chk("rn_done_early", 32'(run_done), 32'(0));
      chk("rn_illegal", 32'(illegal), 32'(0));
      chk("rn_phase", 32'(phase), 32'(idx));
      chk("rn_err", 32'(err_flag), 32'(merr));
      chk("rn_din", 32'(din), 32'(nxt[0]));
      step(nxt[0]);
      idx = (idx + 1) % (2*W);
   endtask

   task automatic do_run(input int n);
      int idx;
      run_start(n, idx);
      for (int s = 0; s < n; s++) run_step(idx);
      chk("rn_done", 32'(run_done), 32'(1));
      chk("rn_busy_end", 32'(busy), 32'(0));
      chk("rn_end_phase", 32'(phase), 32'(idx));
      chk("rn_end_err", 32'(err_flag), 32'(merr));
      step(1'b0);
      chk("rn_done_pulse", 32'(run_done), 32'(0));
      chk("rn_err_hold", 32'(err_flag), 32'(merr));
   endtask

   // Free-run for nsteps, then stop together with a load request: stop wins.
   task automatic do_free(input int nsteps, input logic [W-1:0] pat);
      int idx;
      run_start(0, idx);
      for (int s = 0; s < nsteps; s++) run_step(idx);
      cmd_stop = 1'b1;
      cmd_load = 1'b1;
      load_pat = pat;
      run_step(idx);
      cmd_stop = 1'b0;
      cmd_load = 1'b0;
      chk("fr_busy", 32'(busy), 32'(0));
      chk("fr_run_done", 32'(run_done), 32'(0));
      chk("fr_load_done", 32'(load_done), 32'(0));
      chk("fr_q", 32'(jq), 32'(jcode(idx)));
      idle_cycles(W + 1);
      chk("fr_no_load", 32'(load_done), 32'(0));
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int op;
      logic [W-1:0] pat;
      reset = 1'b0; cmd_run = 1'b0; cmd_load = 1'b0; cmd_stop = 1'b0;
      load_pat = '0; run_len = '0;
      mq = '0; merr = 1'b0;

      // reset and settle
      repeat (4) tick();
      chk("rst_busy", 32'(busy), 32'(0));
      chk("rst_done", 32'({load_done, run_done}), 32'(0));
      reset = 1'b1;
      chk("rel_busy", 32'(busy), 32'(0));
      chk("rel_din", 32'(din), 32'(0));
      chk("rel_err", 32'(err_flag), 32'(0));
      repeat (4) tick();
      chk("rel_q", 32'(jq), 32'(0));
      chk("rel_phase", 32'(phase), 32'(0));
      mq = '0;

      // directed sequence
      do_run(5);
      chk("t2_q", 32'(jq), 32'(4'b1100));   // one idle shift after 1110
      do_load(4'b1010);
      do_run(3);
      do_free(10, 4'b0110);
      do_run(20);

      // reset during second bit of a load
      load_pat = 4'b1101;
      cmd_load = 1'b1;
      step(1'b0);
      cmd_load = 1'b0;
      chk("rl_din1", 32'(din), 32'(1));
      step(1'b1);
      reset = 1'b0;
      #1;
      chk("rl_busy", 32'(busy), 32'(0));
      chk("rl_din", 32'(din), 32'(0));
      #1;
      step(1'b0);
      step(1'b0);
      reset = 1'b1;
      for (int k = 0; k < W + 2; k++) begin
         chk("rl_no_done", 32'(load_done), 32'(0));
         chk("rl_idle_busy", 32'(busy), 32'(0));
         step(1'b0);
      end

      // randomized operation mix
      for (int it = 0; it < 40; it++) begin
         op = $urandom_range(0, 3);
         pat = W'($urandom);
         case (op)
            0: do_load(pat);
            1: do_run($urandom_range(1, 20));
            2: do_free($urandom_range(1, 12), pat);
            default: idle_cycles($urandom_range(1, 3));
         endcase
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
